// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - MSI line states, snoopy bus commands and CPU sequencer states
package msi_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } STATE_TYPE;

  // Five commands need three bits.
  typedef enum logic [2:0] {
    BUS_NONE           = 3'd0,
    BUS_READ           = 3'd1,
    BUS_READ_EXCLUSIVE = 3'd2,
    BUS_INVALIDATE     = 3'd3,
    BUS_WRITEBACK      = 3'd4
  } BusCommand;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARBITRATE  = 3'd1,
    WRITEBACK  = 3'd2,
    FILL       = 3'd3,
    INVALIDATE = 3'd4,
    UPDATE     = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/msi_cpu_controller.sv
// rtl/msi_cpu_controller.sv - CPU-side MSI sequencer: hits, victim write-back, fill, upgrade
import msi_pkg::*;

module msi_cpu_controller #(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 16,
  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  input  logic                     cpuRead,
  input  logic                     cpuWrite,
  input  logic [DATA_WIDTH-1:0]    cpuDataIn,
  output logic [DATA_WIDTH-1:0]    cpuDataOut,
  output logic                     cpuFunctionComplete,
  output logic [INDEX_WIDTH-1:0]   cacheIndex,
  output logic [OFFSET_WIDTH-1:0]  cacheOffset,
  output logic [TAG_WIDTH-1:0]     cacheTagOut,
  input  logic [TAG_WIDTH-1:0]     cacheTagIn,
  input  logic [1:0]               cacheStateIn,
  output logic [1:0]               cacheStateOut,
  input  logic                     cacheHit,
  input  logic [DATA_WIDTH-1:0]    cacheDataIn,
  output logic [DATA_WIDTH-1:0]    cacheDataOut,
  output logic                     cacheWriteTag,
  output logic                     cacheWriteState,
  output logic                     cacheWriteData,
  output logic                     busRequest,
  input  logic                     busGrant,
  output BusCommand                busCommand,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic [DATA_WIDTH-1:0]    busDataOut,
  input  logic [DATA_WIDTH-1:0]    busDataIn,
  output logic                     busRead,
  output logic                     busWrite,
  input  logic                     busFunctionComplete
);

  logic [TAG_WIDTH-1:0]    cpu_tag;
  logic [INDEX_WIDTH-1:0]  cpu_index;
  logic [OFFSET_WIDTH-1:0] cpu_offset;
  ctrl_state_t             state, next_state;
  logic [OFFSET_WIDTH-1:0] count;
  logic                    last_word;
  logic                    word_done;

  assign {cpu_tag, cpu_index, cpu_offset} = cpuAddress;
  assign last_word = (count == {OFFSET_WIDTH{1'b1}});
  assign word_done = busFunctionComplete && (state == WRITEBACK || state == FILL);

  // The word counter restarts on every state change, so the fill after a write-back starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        count <= '0;
      else if (word_done)
        count <= count + 1'b1;
    end
  end

  always_comb begin
    next_state          = state;
    cpuDataOut          = '0;
    cpuFunctionComplete = 1'b0;
    cacheIndex          = '0;
    cacheOffset         = '0;
    cacheTagOut         = '0;
    cacheStateOut       = INVALID;
    cacheDataOut        = '0;
    cacheWriteTag       = 1'b0;
    cacheWriteState     = 1'b0;
    cacheWriteData      = 1'b0;
    busRequest          = 1'b0;
    busCommand          = BUS_NONE;
    busAddress          = '0;
    busDataOut          = '0;
    busRead             = 1'b0;
    busWrite            = 1'b0;
    // Outputs are combinational, so reset must force them low even while a request is held.
    if (!reset) begin
      cacheIndex  = cpu_index;
      cacheOffset = cpu_offset;
      cacheTagOut = cpu_tag;
      unique case (state)
        IDLE: begin
          if (cpuRead && cacheHit) begin
            cpuDataOut          = cacheDataIn;
            cpuFunctionComplete = 1'b1;
          end else if (cpuWrite && cacheHit && cacheStateIn == MODIFIED) begin
            cacheWriteData      = 1'b1;
            cacheDataOut        = cpuDataIn;
            cpuFunctionComplete = 1'b1;
          end else if (cpuRead || cpuWrite) begin
            next_state = ARBITRATE;
          end
        end
        ARBITRATE: begin
          busRequest = 1'b1;
          // The snooper may have invalidated the line while we waited for the grant.
          if (busGrant) begin
            if (cpuWrite && cacheHit && cacheStateIn == SHARED)
              next_state = INVALIDATE;
            else if (!cacheHit && cacheStateIn == MODIFIED)
              next_state = WRITEBACK;
            else
              next_state = FILL;
          end
        end
        WRITEBACK: begin
          busRequest  = 1'b1;
          busCommand  = BUS_WRITEBACK;
          cacheOffset = count;
          busAddress  = {cacheTagIn, cpu_index, count};
          busDataOut  = cacheDataIn;
          busWrite    = 1'b1;
          if (busFunctionComplete && last_word)
            next_state = FILL;
        end
        FILL: begin
          busRequest  = 1'b1;
          busCommand  = cpuWrite ? BUS_READ_EXCLUSIVE : BUS_READ;
          cacheOffset = count;
          busAddress  = {cpu_tag, cpu_index, count};
          busRead     = 1'b1;
          if (busFunctionComplete) begin
            cacheWriteData = 1'b1;
            cacheDataOut   = busDataIn;
            if (last_word)
              next_state = UPDATE;
          end
        end
        INVALIDATE: begin
          busRequest = 1'b1;
          busCommand = BUS_INVALIDATE;
          busAddress = cpuAddress;
          next_state = UPDATE;
        end
        UPDATE: begin
          cacheWriteTag   = 1'b1;
          cacheWriteState = 1'b1;
          cacheStateOut   = cpuWrite ? MODIFIED : SHARED;
          next_state      = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_cpu_controller.sv
// tb/tb_msi_cpu_controller.sv - bench with cache store, bus memory, arbiter and scoreboard
import msi_pkg::*;

module tb_msi_cpu_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpuAddress;
  logic        cpuRead, cpuWrite;
  logic [15:0] cpuDataIn, cpuDataOut;
  logic        cpuFunctionComplete;
  logic [3:0]  cacheIndex, cacheOffset;
  logic [7:0]  cacheTagOut, cacheTagIn;
  logic [1:0]  cacheStateIn, cacheStateOut;
  logic        cacheHit;
  logic [15:0] cacheDataIn, cacheDataOut;
  logic        cacheWriteTag, cacheWriteState, cacheWriteData;
  logic        busRequest;
  logic        busGrant;
  BusCommand   busCommand;
  logic [15:0] busAddress, busDataOut, busDataIn;
  logic        busRead, busWrite;
  logic        busFunctionComplete;

  msi_cpu_controller dut (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuFunctionComplete(cpuFunctionComplete),
    .cacheIndex(cacheIndex), .cacheOffset(cacheOffset), .cacheTagOut(cacheTagOut),
    .cacheTagIn(cacheTagIn), .cacheStateIn(cacheStateIn), .cacheStateOut(cacheStateOut),
    .cacheHit(cacheHit), .cacheDataIn(cacheDataIn), .cacheDataOut(cacheDataOut),
    .cacheWriteTag(cacheWriteTag), .cacheWriteState(cacheWriteState),
    .cacheWriteData(cacheWriteData),
    .busRequest(busRequest), .busGrant(busGrant), .busCommand(busCommand),
    .busAddress(busAddress), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .busRead(busRead), .busWrite(busWrite), .busFunctionComplete(busFunctionComplete)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_item_t;

  bus_item_t   exp_bus[$];
  logic [15:0] exp_rd[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Cache store model; pokes preload lines or mimic a snooper.
  logic [7:0]  tags [16];
  logic [1:0]  states [16];
  logic [15:0] store [16][16];
  logic        poke = 1'b0, poke_fill = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [7:0]  poke_tag = '0;
  logic [1:0]  poke_state = '0;
  logic [15:0] poke_base = '0;

  assign cacheTagIn   = tags[cacheIndex];
  assign cacheStateIn = states[cacheIndex];
  assign cacheDataIn  = store[cacheIndex][cacheOffset];
  assign cacheHit     = (states[cacheIndex] != INVALID) && (tags[cacheIndex] == cacheTagOut);

  always @(posedge clock) begin
    if (poke) begin
      tags[poke_idx]   <= poke_tag;
      states[poke_idx] <= poke_state;
      if (poke_fill)
        for (int w = 0; w < 16; w++) store[poke_idx][w] <= poke_base + 16'(w);
    end else begin
      if (cacheWriteTag)   tags[cacheIndex]   <= cacheTagOut;
      if (cacheWriteState) states[cacheIndex] <= cacheStateOut;
      if (cacheWriteData)  store[cacheIndex][cacheOffset] <= cacheDataOut;
    end
  end

  // Bus memory: ack every other cycle; arbiter grants after a short delay.
  logic [1:0] gcnt = '0;
  initial busFunctionComplete = 1'b0;
  initial busGrant = 1'b0;
  assign busDataIn = mem_word(busAddress);

  always @(posedge clock) begin
    busFunctionComplete <= (busRead || busWrite) && !busFunctionComplete;
    if (!busRequest) begin
      busGrant <= 1'b0;
      gcnt     <= '0;
    end else if (gcnt == 2'd2) begin
      busGrant <= 1'b1;
    end else begin
      gcnt <= gcnt + 2'd1;
    end
  end

  always @(negedge clock) begin
    bus_item_t it;
    if (busRequest) req_cycles++;
    if ((busFunctionComplete && (busRead || busWrite)) ||
        (busRequest && busGrant && busCommand == BUS_INVALIDATE)) begin
      if (exp_bus.size() == 0) begin
        check("bus_unexpected", 32'(busCommand), 32'(BUS_NONE));
      end else begin
        it = exp_bus.pop_front();
        check("bus_cmd", 32'(busCommand), 32'(it.cmd));
        if (busCommand != BUS_INVALIDATE) check("bus_addr", 32'(busAddress), 32'(it.addr));
        if (busWrite) check("wb_data", 32'(busDataOut), 32'(it.data));
      end
    end
    if (cpuFunctionComplete && cpuRead) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 32'(cpuDataOut), 32'hDEAD);
      else check("rd_data", 32'(cpuDataOut), 32'(exp_rd.pop_front()));
    end
  end

  logic any_out;
  assign any_out = |{cpuDataOut, cpuFunctionComplete, cacheIndex, cacheOffset, cacheTagOut,
                     cacheStateOut, cacheDataOut, cacheWriteTag, cacheWriteState, cacheWriteData,
                     busRequest, busCommand, busAddress, busDataOut, busRead, busWrite};

  task automatic poke_line(input logic [3:0] idx, input logic [7:0] tag, input logic [1:0] st,
                           input logic fill, input logic [15:0] base);
    poke_idx = idx; poke_tag = tag; poke_state = st; poke_fill = fill; poke_base = base;
    poke = 1'b1;
    @(posedge clock); #1;
    poke = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat);
    cpuAddress = a; cpuDataIn = d; cpuWrite = wr; cpuRead = !wr;
    lat = 0;
    @(negedge clock);
    while (!cpuFunctionComplete && lat < 400) begin
      lat++;
      @(negedge clock);
    end
    if (!cpuFunctionComplete) check("req_timeout", 32'(lat), 32'd0);
    @(posedge clock); #1;
    cpuRead = 1'b0; cpuWrite = 1'b0;
  endtask

  task automatic push_seq(input BusCommand c, input logic [15:0] base, input int n,
                          input logic [15:0] dbase);
    for (int w = 0; w < n; w++) exp_bus.push_back({c, base + 16'(w), dbase + 16'(w)});
  endtask

  int lat, rq0;
  logic seen;

  initial begin
    reset = 1'b1; cpuAddress = '0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuDataIn = '0;
    for (int i = 0; i < 16; i++) poke_line(4'(i), 8'h00, INVALID, 1'b1, 16'h0000);
    check("reset_outs", 32'(any_out), 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // 1: read hit, zero wait, no bus activity
    poke_line(4'd3, 8'h12, SHARED, 1'b1, 16'h3000);
    exp_rd.push_back(16'h3005);
    rq0 = req_cycles;
    do_req(1'b0, 16'h1235, 16'h0, lat);
    check("hit_latency", 32'(lat), 32'd0);
    check("hit_no_busreq", 32'(req_cycles - rq0), 32'd0);

    // 2: read miss on clean line
    push_seq(BUS_READ, 16'h4A20, 16, 16'h0);
    exp_rd.push_back(mem_word(16'h4A20));
    do_req(1'b0, 16'h4A20, 16'h0, lat);
    check("miss_state", 32'(states[2]), 32'(SHARED));
    check("miss_tag", 32'(tags[2]), 32'h4A);
    check("miss_word15", 32'(store[2][15]), 32'(mem_word(16'h4A2F)));

    // 3: dirty miss: write-back then exclusive fill
    poke_line(4'd2, 8'h4A, MODIFIED, 1'b1, 16'hD000);
    push_seq(BUS_WRITEBACK, 16'h4A20, 16, 16'hD000);
    push_seq(BUS_READ_EXCLUSIVE, 16'h7720, 16, 16'h0);
    do_req(1'b1, 16'h7720, 16'hBEEF, lat);
    check("dirty_state", 32'(states[2]), 32'(MODIFIED));
    check("dirty_tag", 32'(tags[2]), 32'h77);
    check("dirty_word0", 32'(store[2][0]), 32'hBEEF);
    check("dirty_word1", 32'(store[2][1]), 32'(mem_word(16'h7721)));

    // 4: upgrade of a SHARED line
    poke_line(4'd5, 8'h33, SHARED, 1'b1, 16'h5000);
    exp_bus.push_back({BUS_INVALIDATE, 16'h3357, 16'h0});
    do_req(1'b1, 16'h3357, 16'h1234, lat);
    check("upg_state", 32'(states[5]), 32'(MODIFIED));
    check("upg_word7", 32'(store[5][7]), 32'h1234);
    check("upg_word6", 32'(store[5][6]), 32'h5006);

    // 5: snoop invalidates the line before the grant arrives
    poke_line(4'd6, 8'h21, SHARED, 1'b1, 16'h6000);
    push_seq(BUS_READ_EXCLUSIVE, 16'h2160, 16, 16'h0);
    fork
      do_req(1'b1, 16'h2160, 16'h5555, lat);
      begin
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge clock);
          if (busRequest && !busGrant) seen = 1'b1;
        end
        check("race_req_seen", 32'(seen), 32'd1);
        poke_line(4'd6, 8'h21, INVALID, 1'b0, 16'h0);
      end
    join
    check("race_state", 32'(states[6]), 32'(MODIFIED));
    check("race_word0", 32'(store[6][0]), 32'h5555);

    // 6: reset during fill word 7, then a clean refill
    push_seq(BUS_READ, 16'h9A80, 7, 16'h0);
    cpuAddress = 16'h9A80; cpuRead = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clock);
      if (busRead && busAddress[3:0] == 4'd7 && !busFunctionComplete) seen = 1'b1;
    end
    check("fill_w7_seen", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1 check("rst_outs_zero", 32'(any_out), 32'd0);
    check("rst_drained", 32'(exp_bus.size()), 32'd0);
    push_seq(BUS_READ, 16'h9A80, 16, 16'h0);
    exp_rd.push_back(mem_word(16'h9A80));
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    lat = 0;
    @(negedge clock);
    while (!cpuFunctionComplete && lat < 400) begin
      lat++;
      @(negedge clock);
    end
    check("refill_done", 32'(cpuFunctionComplete), 32'd1);
    @(posedge clock); #1 cpuRead = 1'b0;
    check("refill_state", 32'(states[8]), 32'(SHARED));
    check("refill_tag", 32'(tags[8]), 32'h9A);

    repeat (4) @(posedge clock);
    check("bus_left", 32'(exp_bus.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
